// File: rtl/systolic_word_feeder.sv
// -----------------------------------------------------------------------------
// systolic_word_feeder
//
// Upstream stage of the systolic PE chain. Samples arrive at an irregular rate
// over a valid/ready handshake and are queued in a small FIFO. Each slot lasts
// SLOT_CYCLES clocks. At every slot boundary the FIFO head is moved onto
// feedword and held there for the whole slot. Slot and frame timing are
// generated here and stay aligned to the PE's internal count/wordIndex.
//
// Ports
//   clk30x       in   clock, all logic on the rising edge
//   reset        in   synchronous, active-high
//   in_word      in   incoming sample (two's complement, passed through untouched)
//   in_valid     in   in_word is valid
//   in_ready     out  FIFO can accept a sample (not full)
//   feedword     out  word presented to the PE chain, constant within a slot
//   slot_start   out  first cycle of a slot
//   word_index   out  slot number within the frame
//   frame_start  out  first cycle of slot 0 of a frame
//   fifo_level   out  registered FIFO occupancy, 0..FIFO_DEPTH
//   underflow    out  sticky flag: a slot began while the FIFO was empty
// -----------------------------------------------------------------------------
module systolic_word_feeder #(
    parameter int WORDLENGTH  = 16,
    parameter int SLOT_CYCLES = 30,
    parameter int FRAME_WORDS = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk30x,
    input  logic                          reset,
    input  logic [WORDLENGTH-1:0]         in_word,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WORDLENGTH-1:0]         feedword,
    output logic                          slot_start,
    output logic [$clog2(FRAME_WORDS)-1:0] word_index,
    output logic                          frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int SC_W  = $clog2(SLOT_CYCLES);
    localparam int WI_W  = $clog2(FRAME_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [SC_W-1:0]  SLOT_LAST  = SC_W'(SLOT_CYCLES - 1);
    localparam logic [WI_W-1:0]  FRAME_LAST = WI_W'(FRAME_WORDS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [SC_W-1:0]       slot_count_reg,  slot_count_next;
    logic [WI_W-1:0]       word_index_reg,  word_index_next;
    logic [PTR_W-1:0]      rd_ptr_reg,      rd_ptr_next;
    logic [PTR_W-1:0]      wr_ptr_reg,      wr_ptr_next;
    logic [LVL_W-1:0]      level_reg,       level_next;
    logic [WORDLENGTH-1:0] feedword_reg,    feedword_next;
    logic                  underflow_reg,   underflow_next;

    logic [WORDLENGTH-1:0] fifo_mem [FIFO_DEPTH];

    logic boundary;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    // ---------------------------------------------------------------------
    // Control decode
    // ---------------------------------------------------------------------
    // The boundary is the edge on which slot_count wraps to 0. Emptiness is
    // judged on the registered level, so a word pushed on that same edge is
    // not forwarded: that slot underflows and the word waits for the next.
    assign boundary   = (slot_count_reg == SLOT_LAST);
    assign fifo_full  = (level_reg == LVL_FULL);
    assign fifo_empty = (level_reg == '0);
    assign push       = in_valid && !fifo_full;
    assign pop        = boundary && !fifo_empty;

    always_comb begin
        slot_count_next = slot_count_reg + SC_W'(1);
        word_index_next = word_index_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        level_next      = level_reg;
        feedword_next   = feedword_reg;
        underflow_next  = underflow_reg;

        if (boundary) begin
            slot_count_next = '0;
            word_index_next = (word_index_reg == FRAME_LAST) ? '0
                                                             : word_index_reg + WI_W'(1);
            if (fifo_empty) begin
                feedword_next  = '0;
                underflow_next = 1'b1;
            end else begin
                feedword_next  = fifo_mem[rd_ptr_reg];
            end
        end

        // FIFO_DEPTH is a power of two, so pointers wrap naturally.
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // Counters reset to their last values so the first active edge after
    // reset opens slot 0 of frame 0, matching the PE count resetting to -1.
    always_ff @(posedge clk30x) begin
        if (reset) begin
            slot_count_reg <= SLOT_LAST;
            word_index_reg <= FRAME_LAST;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            level_reg      <= '0;
            feedword_reg   <= '0;
            underflow_reg  <= 1'b0;
        end else begin
            slot_count_reg <= slot_count_next;
            word_index_reg <= word_index_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            level_reg      <= level_next;
            feedword_reg   <= feedword_next;
            underflow_reg  <= underflow_next;
        end
    end

    // Storage array; contents need no reset because the pointers and level
    // define which entries are meaningful.
    always_ff @(posedge clk30x) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_reg] <= in_word;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign in_ready    = !fifo_full;
    assign feedword    = feedword_reg;
    assign slot_start  = (slot_count_reg == '0);
    assign word_index  = word_index_reg;
    assign frame_start = slot_start && (word_index_reg == '0);
    assign fifo_level  = level_reg;
    assign underflow   = underflow_reg;

endmodule

// File: tb/tb_systolic_word_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_word_feeder
//
// Directed test of systolic_word_feeder. A queue-based reference model tracks
// the number of clock edges since reset, the FIFO contents and the presented
// word; a compare process checks every DUT output against it on each falling
// edge. Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_systolic_word_feeder;

    localparam int W     = 16;
    localparam int SLOT  = 30;
    localparam int FRAME = 8;
    localparam int DEPTH = 4;

    logic          clk30x;
    logic          reset;
    logic [W-1:0]  in_word;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  feedword;
    logic          slot_start;
    logic [2:0]    word_index;
    logic          frame_start;
    logic [2:0]    fifo_level;
    logic          underflow;

    int checks   = 0;
    int failures = 0;
    int fail_prints = 0;

    systolic_word_feeder #(
        .WORDLENGTH (W),
        .SLOT_CYCLES(SLOT),
        .FRAME_WORDS(FRAME),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk30x     (clk30x),
        .reset      (reset),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .feedword   (feedword),
        .slot_start (slot_start),
        .word_index (word_index),
        .frame_start(frame_start),
        .fifo_level (fifo_level),
        .underflow  (underflow)
    );

    initial begin
        clk30x = 1'b0;
        forever #5 clk30x = ~clk30x;
    end

    // ---------------------------------------------------------------------
    // Reference model: n counts active edges since reset released. Edge n
    // (0-based) is a slot boundary when n is a multiple of SLOT.
    // ---------------------------------------------------------------------
    logic [W-1:0] q[$];
    int           model_n    = 0;
    logic [W-1:0] model_feed = '0;
    logic         model_uf   = 1'b0;
    logic         model_live = 1'b0;

    always @(posedge clk30x) begin
        if (reset) begin
            q.delete();
            model_n    = 0;
            model_feed = '0;
            model_uf   = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            int  had;
            bit  acc;
            had = q.size();
            acc = in_valid && (had < DEPTH);
            if (model_n % SLOT == 0) begin
                if (had > 0) begin
                    model_feed = q.pop_front();
                end else begin
                    model_feed = '0;
                    model_uf   = 1'b1;
                end
            end
            if (acc) q.push_back(in_word);
            model_n = model_n + 1;
        end
    end

    function automatic int exp_word_index();
        if (model_n == 0) return FRAME - 1;
        return ((model_n - 1) / SLOT) % FRAME;
    endfunction

    function automatic bit exp_slot_start();
        return (model_n >= 1) && (((model_n - 1) % SLOT) == 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            if (fail_prints < 40) begin
                fail_prints = fail_prints + 1;
                $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
            end
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk30x) begin
        if (model_live) begin
            check("cmp_feedword",   int'(feedword),    int'(model_feed));
            check("cmp_in_ready",   int'(in_ready),    int'(q.size() < DEPTH));
            check("cmp_slot_start", int'(slot_start),  int'(exp_slot_start()));
            check("cmp_word_index", int'(word_index),  exp_word_index());
            check("cmp_frame_start",int'(frame_start), int'(exp_slot_start() && exp_word_index() == 0));
            check("cmp_fifo_level", int'(fifo_level),  q.size());
            check("cmp_underflow",  int'(underflow),   int'(model_uf));
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk30x);
        #1;
    endtask

    // Advance until the next rising edge is a slot boundary.
    task automatic to_boundary();
        for (int k = 0; k < 2 * SLOT && (model_n % SLOT) != 0; k++) tick();
        check("to_boundary_reached", model_n % SLOT, 0);
    endtask

    task automatic push_one(input logic [W-1:0] w);
        in_word  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_word  = '0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_word  = '0;

        // Test 1: reset and idle timing
        repeat (3) tick();
        check("t1_rst_feedword",   int'(feedword),   0);
        check("t1_rst_in_ready",   int'(in_ready),   1);
        check("t1_rst_word_index", int'(word_index), 7);
        check("t1_rst_slot_start", int'(slot_start), 0);
        check("t1_rst_level",      int'(fifo_level), 0);
        check("t1_rst_underflow",  int'(underflow),  0);
        reset = 1'b0;
        tick();
        check("t1_first_slot_start",  int'(slot_start),  1);
        check("t1_first_frame_start", int'(frame_start), 1);
        check("t1_first_word_index",  int'(word_index),  0);
        check("t1_first_underflow",   int'(underflow),   1);
        tick();
        check("t1_slot_start_low", int'(slot_start), 0);
        repeat (29) tick();
        check("t1_slot1_start",       int'(slot_start),  1);
        check("t1_slot1_word_index",  int'(word_index),  1);
        check("t1_slot1_frame_start", int'(frame_start), 0);
        repeat (210) tick();
        check("t1_frame2_start", int'(frame_start), 1);

        // Test 2: fill the FIFO, then drain one word per slot
        push_one(16'h0001);
        push_one(16'h0002);
        push_one(16'h0003);
        push_one(16'h0004);
        check("t2_full_level",    int'(fifo_level), 4);
        check("t2_full_in_ready", int'(in_ready),   0);
        push_one(16'h0BAD);
        check("t2_no_overwrite_level", int'(fifo_level), 4);
        to_boundary();
        tick();
        check("t2_word1", int'(feedword), 16'h0001);
        check("t2_level3", int'(fifo_level), 3);
        repeat (29) tick();
        check("t2_word1_held", int'(feedword), 16'h0001);
        tick();
        check("t2_word2", int'(feedword), 16'h0002);
        to_boundary();
        tick();
        check("t2_word3", int'(feedword), 16'h0003);
        to_boundary();
        tick();
        check("t2_word4", int'(feedword), 16'h0004);
        check("t2_drained", int'(fifo_level), 0);

        // Test 3: push coincident with a boundary pop, one entry held
        tick();
        push_one(16'h0A0A);
        check("t3_level1", int'(fifo_level), 1);
        to_boundary();
        push_one(16'h7FFF);
        check("t3_level_same_a", int'(fifo_level), 1);
        check("t3_feed_0a0a",    int'(feedword),   16'h0A0A);
        to_boundary();
        push_one(16'h8000);
        check("t3_level_same_b", int'(fifo_level), 1);
        check("t3_feed_7fff",    int'(feedword),   16'h7FFF);
        to_boundary();
        tick();
        check("t3_feed_8000", int'(feedword),   16'h8000);
        check("t3_level0",    int'(fifo_level), 0);

        // Test 4: empty at boundary -> zero word, underflow sticky
        to_boundary();
        tick();
        check("t4_zero_word", int'(feedword),  0);
        check("t4_underflow", int'(underflow), 1);
        push_one(16'h5555);
        check("t4_underflow_sticky", int'(underflow),  1);
        check("t4_level1",           int'(fifo_level), 1);
        to_boundary();
        tick();
        check("t4_feed_5555", int'(feedword), 16'h5555);

        // Test 5: push into empty FIFO on the boundary edge is not bypassed
        to_boundary();
        push_one(16'h1234);
        check("t5_no_bypass", int'(feedword),   0);
        check("t5_level1",    int'(fifo_level), 1);
        to_boundary();
        tick();
        check("t5_next_slot", int'(feedword),   16'h1234);
        check("t5_level0",    int'(fifo_level), 0);

        // Test 6: mid-slot reset with 3 entries queued
        tick();
        push_one(16'h1111);
        push_one(16'h2222);
        push_one(16'h3333);
        check("t6_level3", int'(fifo_level), 3);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("t6_rst_level",      int'(fifo_level), 0);
        check("t6_rst_feedword",   int'(feedword),   0);
        check("t6_rst_underflow",  int'(underflow),  0);
        check("t6_rst_word_index", int'(word_index), 7);
        check("t6_rst_slot_start", int'(slot_start), 0);
        check("t6_rst_in_ready",   int'(in_ready),   1);
        tick();
        reset = 1'b0;
        tick();
        check("t6_slot_start",  int'(slot_start),  1);
        check("t6_frame_start", int'(frame_start), 1);
        repeat (240) tick();
        check("t6_frame_again", int'(frame_start), 1);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
